// File: rtl/cpu_axi_bridge_if.sv
// AXI3 master-side signal bundle for the CPU bridge.
// The master modport is the bridge; the slave modport is the interconnect or memory.
interface cpu_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Converts the core's instruction and data SRAM-style requests into one AXI3 master port,
// one transaction in flight; data has priority, fetches are 2-beat bursts.
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [63:0] inst_rdata,
  output logic        inst_done,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  cpu_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        is_inst_q;
  logic [31:0] addr_q, wdata_q, low_q;
  logic [3:0]  wstrb_q;
  logic        beat_q, aw_done_q, w_done_q;
  logic        inst_done_q, data_done_q;
  logic [63:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = axi.arvalid & axi.arready;
  assign r_hs  = axi.rvalid & axi.rready;
  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid & axi.wready;
  assign b_hs  = axi.bvalid & axi.bready;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Held requests must not re-issue while their done pulse is still high.
        if (!inst_done_q && !data_done_q && (data_req || inst_req)) begin
          accept  = 1'b1;
          state_d = (data_req && (data_wen != 4'b0000)) ? StAwW : StAr;
        end
      end
      StAr:  if (ar_hs) state_d = StR;
      StR:   if (r_hs && axi.rlast) state_d = StIdle;
      StAwW: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StB;
      StB:   if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      is_inst_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      low_q        <= '0;
      beat_q       <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
      if (accept) begin
        is_inst_q <= !data_req;
        addr_q    <= data_req ? data_addr : {inst_addr[31:3], 3'b000};
        wdata_q   <= data_wdata;
        wstrb_q   <= data_wen;
        beat_q    <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (r_hs) begin
        if (is_inst_q) begin
          if (axi.rlast) begin
            inst_done_q  <= 1'b1;
            // A burst cut short after beat 0 leaves the upper word zero.
            inst_rdata_q <= beat_q ? {axi.rdata, low_q} : {32'h0, axi.rdata};
          end else if (!beat_q) begin
            low_q  <= axi.rdata;
            beat_q <= 1'b1;
          end
        end else if (axi.rlast) begin
          data_done_q  <= 1'b1;
          data_rdata_q <= axi.rdata;
        end
      end
      if (b_hs) data_done_q <= 1'b1;
    end
  end

  assign axi.arvalid = (state_q == StAr);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = is_inst_q ? 4'd1 : 4'd0;
  assign axi.arid    = is_inst_q ? INST_ID : DATA_ID;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.rready  = (state_q == StR);

  assign axi.awvalid = (state_q == StAwW) && !aw_done_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.awid    = DATA_ID;
  assign axi.wvalid  = (state_q == StAwW) && !w_done_q;
  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = (state_q == StB);

  assign inst_done  = inst_done_q;
  assign inst_rdata = inst_rdata_q;
  assign data_done  = data_done_q;
  assign data_rdata = data_rdata_q;

  // IDs and responses carry no information for a single-outstanding master.
  logic unused_bits;
  assign unused_bits = ^{axi.rid, axi.rresp, axi.bid, axi.bresp, inst_addr[2:0]};

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU top; consumes its post-MMU instruction and data SRAM-style requests and converts them to a single AXI3 master port.
- Arbitrates between the instruction and data sides, with one outstanding transaction at a time.
- Fetches 64-bit instruction pairs as a 2-beat burst; handles data as single-beat reads or writes.
- Returns response pulses so the core can stall until each request completes.

Parameters:
INST_ID, 4'd0, ARID used for instruction fetches
DATA_ID, 4'd1, ARID/AWID used for data accesses

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request, held high until inst_done
inst_addr  in  32  physical fetch address; low 3 bits ignored
inst_rdata  out  64  {beat1, beat0}, valid when inst_done
inst_done  out  1  1-cycle completion pulse
data_req  in  1  data request, held stable until data_done
data_wen  in  4  byte strobes; 0 = read
data_addr  in  32  physical, word-aligned
data_wdata  in  32  store data
data_rdata  out  32  load data, valid when data_done
data_done  out  1  1-cycle completion pulse
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/4/3/2/1  AXI read address
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
rready  out  1
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1  AXI write address
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1
wready  in  1
bid/bresp/bvalid  in  4/2/1
bready  out  1

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - arvalid, awvalid, wvalid, rready, bready, inst_done, data_done = 0.
  - inst_rdata, data_rdata = 0.
  - Any in-flight transaction is abandoned.
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE:
  - data_req wins over inst_req.
  - data_req with data_wen!=0 -> AW_W; data_req with data_wen==0 -> AR (data); else inst_req -> AR (inst).
  - Request fields are latched on the IDLE exit edge.
  - No new request is accepted in the cycle a done pulse is asserted.
- AR:
  - arvalid=1. Fields are constant while arvalid=1.
  - Inst fetch: araddr = {inst_addr[31:3], 3'b000}, arlen=1, arid=INST_ID.
  - Data read: araddr = data_addr, arlen=0, arid=DATA_ID.
  - arsize=2, arburst=INCR.
  - arvalid&arready -> R next cycle.
- R:
  - rready=1.
  - Inst fetch: beat counter 0->1; beat0 -> inst_rdata[31:0], beat1 -> inst_rdata[63:32].
  - On rvalid&rlast: inst_done=1 (or data_done=1 with data_rdata=rdata) in the following cycle; return to IDLE.
  - rresp is ignored. rlast on beat0 of an inst fetch completes with the upper word = 0.
- AW_W:
  - awvalid and wvalid are raised together; each drops independently after its own handshake.
  - Fields: awaddr=data_addr, awlen=0, awsize=2, awburst=INCR, awid=wid=DATA_ID, wdata=data_wdata, wstrb=data_wen, wlast=1.
  - When both handshakes are done (same cycle or different cycles) -> B.
- B:
  - bready=1.
  - bvalid -> data_done=1 next cycle; return to IDLE. bresp is ignored.
- Latency with zero-wait slave:
  - Data read: data_done 4 cycles after the request is seen in IDLE.
  - Inst fetch: inst_done 5 cycles after the request is seen in IDLE.
  - Write: data_done 4 cycles after the request is seen in IDLE.
- Done pulses are exactly 1 cycle. Rdata outputs hold until the next completion.
- A request dropped mid-transaction does not abort it; the transaction completes and the pulse still fires.

Test Plan:
1. Reset held, slave idle -> all valids/readies/done = 0. Release -> state IDLE, no AXI activity.
2. inst_req, inst_addr=0x1FC0_0004; slave returns 0x11111111 then 0x22222222 (rlast) -> araddr=0x1FC0_0000, arlen=1, arid=0; inst_rdata=0x22222222_11111111; one inst_done pulse.
3. Simultaneous inst_req and data_req read at 0x0000_0100, rdata=0xDEADBEEF -> data serviced first (arid=1, arlen=0), data_done with 0xDEADBEEF; then the fetch issues.
4. Store data_wen=4'b0011, addr 0x200, wdata 0xAABBCCDD; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, wstrb=0011; data_done one cycle after bvalid.
5. Inst fetch with arready stalled 5 cycles and rvalid gaps between beats -> araddr/arlen stable throughout; correct beat ordering; a single done pulse.
6. resetn asserted while in R mid-burst -> outputs zero immediately; after release, a new fetch completes normally and stale beats are not merged.
